// File: rtl/shift_pipe_unit_if.sv
// Handshake bundle for shift_pipe_unit: operand/control in, tagged result out, plus flush and busy.
// master = the surrounding pipeline (upstream and downstream), slave = the shift unit.
interface shift_pipe_unit_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_operand;
  logic [4:0]       ctrl_shiftamt;
  logic             ctrl_shiftop;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output flush, in_valid, data_operand, ctrl_shiftamt, ctrl_shiftop, in_tag, out_ready,
    input  in_ready, out_valid, data_result, out_tag, busy
  );

  modport slave (
    input  flush, in_valid, data_operand, ctrl_shiftamt, ctrl_shiftop, in_tag, out_ready,
    output in_ready, out_valid, data_result, out_tag, busy
  );
endinterface

// File: rtl/shift_pipe_unit.sv
// Two-stage 32-bit barrel shifter (SLL / SRA) with valid/ready handshake, tag passthrough and flush.
// Stage 1 applies the 16/8 shifts, stage 2 the 4/2/1 shifts; outputs come straight from stage 2.
module shift_pipe_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  shift_pipe_unit_if.slave   bus
);

  logic signed [WIDTH-1:0] data_p1;
  logic [2:0]              amt_p1;
  logic                    op_p1;
  logic [TAG_W-1:0]        tag_p1;
  logic                    vld_p1;

  logic signed [WIDTH-1:0] data_p2;
  logic [TAG_W-1:0]        tag_p2;
  logic                    vld_p2;

  logic s1_adv;
  logic s2_adv;
  logic accept;

  // Coarse shifts by 16 and 8; the signed type makes >>> replicate bit 31.
  function automatic logic signed [WIDTH-1:0] shift_coarse(
    input logic signed [WIDTH-1:0] d,
    input logic [1:0]              amt,
    input logic                    sra
  );
    logic signed [WIDTH-1:0] s;
    s = d;
    if (amt[1]) s = sra ? (s >>> 16) : (s << 16);
    if (amt[0]) s = sra ? (s >>> 8)  : (s << 8);
    return s;
  endfunction

  // Fine shifts by 4, 2 and 1; bit 31 of the stage-1 value still equals the original sign.
  function automatic logic signed [WIDTH-1:0] shift_fine(
    input logic signed [WIDTH-1:0] d,
    input logic [2:0]              amt,
    input logic                    sra
  );
    logic signed [WIDTH-1:0] s;
    s = d;
    if (amt[2]) s = sra ? (s >>> 4) : (s << 4);
    if (amt[1]) s = sra ? (s >>> 2) : (s << 2);
    if (amt[0]) s = sra ? (s >>> 1) : (s << 1);
    return s;
  endfunction

  assign s2_adv       = !vld_p2 | bus.out_ready;
  assign s1_adv       = !vld_p1 | s2_adv;
  assign bus.in_ready = reset_n & s1_adv & !bus.flush;
  assign accept       = bus.in_valid & bus.in_ready;

  // Stage 1: coarse shift, carry remaining amount, op and tag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      amt_p1  <= '0;
      op_p1   <= 1'b0;
      tag_p1  <= '0;
    end else begin
      if (bus.flush)
        vld_p1 <= 1'b0;
      else if (s1_adv)
        vld_p1 <= accept;
      if (s1_adv) begin
        data_p1 <= shift_coarse($signed(bus.data_operand), bus.ctrl_shiftamt[4:3], bus.ctrl_shiftop);
        amt_p1  <= bus.ctrl_shiftamt[2:0];
        op_p1   <= bus.ctrl_shiftop;
        tag_p1  <= bus.in_tag;
      end
    end
  end

  // Stage 2: fine shift into the output register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      tag_p2  <= '0;
    end else begin
      if (bus.flush)
        vld_p2 <= 1'b0;
      else if (s2_adv)
        vld_p2 <= vld_p1;
      if (s2_adv) begin
        data_p2 <= shift_fine(data_p1, amt_p1, op_p1);
        tag_p2  <= tag_p1;
      end
    end
  end

  assign bus.out_valid   = vld_p2;
  assign bus.data_result = data_p2;
  assign bus.out_tag     = tag_p2;
  assign bus.busy        = vld_p1 | vld_p2;

endmodule

// File: tb/tb_shift_pipe_unit.sv
// Scoreboard bench for shift_pipe_unit: directed vectors push expected results, a monitor pops on handshake.
module tb_shift_pipe_unit;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   pop_cyc[$];

  shift_pipe_unit_if #(.WIDTH(32), .TAG_W(5)) bus ();

  shift_pipe_unit #(.WIDTH(32), .TAG_W(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every completed output handshake must match the oldest expected entry.
  always @(negedge clock) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h required=none", bus.data_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_data", bus.data_result, e.data);
        chk("result_tag", {27'd0, bus.out_tag}, {27'd0, e.tag});
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic send(input logic op, input logic [4:0] amt, input logic [31:0] d,
                      input logic [4:0] t, input logic [31:0] exp_d);
    logic acc;
    int   n;
    exp_t e;
    bus.in_valid      = 1'b1;
    bus.ctrl_shiftop  = op;
    bus.ctrl_shiftamt = amt;
    bus.data_operand  = d;
    bus.in_tag        = t;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clock);
      acc = bus.in_ready;
      if (acc) begin
        e.data = exp_d;
        e.tag  = t;
        sb.push_back(e);
      end
      @(posedge clock);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=%0d required=accepted", n);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clock);
      n++;
    end
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  // Called right after an accept edge: nothing at +1 edge, result visible after +2 edges.
  task automatic check_latency();
    chk("latency_not_early", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clock);
    #1;
    chk("latency_two", {31'd0, bus.out_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush         = 1'b0;
    bus.in_valid      = 1'b1;
    bus.data_operand  = 32'hDEADBEEF;
    bus.ctrl_shiftamt = 5'd3;
    bus.ctrl_shiftop  = 1'b0;
    bus.in_tag        = 5'd1;
    bus.out_ready     = 1'b1;

    // Reset state
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_data_result", bus.data_result, 32'd0);
    chk("rst_out_tag", {27'd0, bus.out_tag}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // SRA with sign fill and latency
    send(1'b1, 5'd4, 32'h8000_0000, 5'd7, 32'hF800_0000);
    check_latency();
    drain();

    // Edge shifts back to back, results on consecutive cycles
    pop_cyc.delete();
    send(1'b0, 5'd31, 32'h0000_0001, 5'd10, 32'h8000_0000);
    send(1'b1, 5'd31, 32'h7FFF_FFFF, 5'd11, 32'h0000_0000);
    send(1'b1, 5'd0,  32'hFFFF_0000, 5'd12, 32'hFFFF_0000);
    drain();
    chk("edge_count", pop_cyc.size(), 3);
    if (pop_cyc.size() == 3) begin
      chk("edge_consec_1", pop_cyc[1] - pop_cyc[0], 1);
      chk("edge_consec_2", pop_cyc[2] - pop_cyc[1], 1);
    end

    // Backpressure: two accepts fill the pipe, then in_ready drops and output holds
    bus.out_ready = 1'b0;
    send(1'b0, 5'd1, 32'h3, 5'd1, 32'h6);
    send(1'b0, 5'd2, 32'h3, 5'd2, 32'hC);
    fork
      begin
        send(1'b0, 5'd3, 32'h3, 5'd3, 32'h18);
        send(1'b0, 5'd4, 32'h3, 5'd4, 32'h30);
      end
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clock);
          chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
          chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
          chk("stall_hold_data", bus.data_result, 32'h6);
        end
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Flush with both stages full, coincident input and coincident output handshake
    bus.out_ready = 1'b0;
    send(1'b0, 5'd1, 32'h1, 5'd5, 32'h2);
    send(1'b0, 5'd2, 32'h1, 5'd6, 32'h4);
    chk("flush_pre_busy", {31'd0, bus.busy}, 32'd1);
    void'(sb.pop_back());
    bus.flush         = 1'b1;
    bus.in_valid      = 1'b1;
    bus.data_operand  = 32'h1;
    bus.ctrl_shiftamt = 5'd5;
    bus.ctrl_shiftop  = 1'b0;
    bus.in_tag        = 5'd8;
    bus.out_ready     = 1'b1;
    @(negedge clock);
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clock);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    repeat (4) @(posedge clock);
    #1;
    chk("flush_queue_empty", sb.size(), 0);

    // Asynchronous reset with two operations in flight
    bus.out_ready = 1'b0;
    send(1'b0, 5'd3, 32'h5, 5'd4, 32'h28);
    send(1'b0, 5'd1, 32'h5, 5'd5, 32'hA);
    #2;
    reset_n = 1'b0;
    sb.delete();
    bus.in_valid = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_data_result", bus.data_result, 32'd0);
    chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clock);
    #1;
    chk("arst_in_ready_hold", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clock);
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    send(1'b1, 5'd8, 32'hF000_0000, 5'd9, 32'hFFF0_0000);
    check_latency();
    drain();

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
